muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer for the integer pipeline.
- Accepts one M-extension operation (funct3 plus two operands) via a valid/ready handshake.
- Sequences a shared shift-add / shift-subtract datapath for XLEN iterations, then applies sign fix-up.
- Holds the result until the writeback stage takes it.
- The pipeline stalls on busy while a long-latency op is in flight.

---
 rtl/muldiv_seq_if.sv | 29 ++
 rtl/muldiv_seq.sv | 148 ++++++++++++++
 tb/tb_muldiv_seq.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_if.sv
// Request/result bundle between the issue stage, muldiv_seq and writeback.
// Pure wiring: no storage and no added latency.
// Flow control: in_valid/in_ready on the request side, out_valid/out_ready on the result side, kill flushes.
interface muldiv_seq_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [2:0]      funct;
   logic [XLEN-1:0] rs1;
   logic [XLEN-1:0] rs2;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            busy;

   // pipeline side: issues ops, consumes results
   modport master (
      output in_valid, funct, rs1, rs2, kill, out_ready,
      input  in_ready, out_valid, result, busy
   );

   // sequencer side
   modport slave (
      input  in_valid, funct, rs1, rs2, kill, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide: shared shift-add / restoring shift-subtract datapath with sign fix-up.
// Latency: XLEN+1 edges after the accept edge; divide-by-zero and signed overflow finish on the accept edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE; kill flushes from any state.
module muldiv_seq #(
   parameter int XLEN = 32
) (
   input  logic         clk,
   input  logic         reset_n,
   muldiv_seq_if.slave  bus
);
   localparam int CW = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

   state_t            state_q;
   logic [2:0]        funct_q;
   logic [XLEN-1:0]   opa_q;        // multiplicand magnitude
   logic [XLEN-1:0]   opb_q;        // divisor magnitude
   logic [2*XLEN-1:0] acc_q;        // mul: {partial hi, multiplier/product lo}; div: {remainder, quotient}
   logic [CW-1:0]     cnt_q;
   logic              neg_q;        // negate the selected magnitude during FIX
   logic              out_valid_q;
   logic [XLEN-1:0]   result_q;

   // accept-time decode
   logic              a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0]   a_abs, b_abs;
   logic              neg_d, div_zero, div_ovf;
   logic [XLEN-1:0]   spec_res_d;
   logic [2*XLEN-1:0] acc_init_d;

   // iteration and fix-up datapath
   logic [XLEN:0]     msum;
   logic [XLEN:0]     rem_sh;
   logic [XLEN:0]     dsub;
   logic [2*XLEN-1:0] acc_step_d;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo_abs, rem_abs;
   logic [XLEN-1:0]   fix_res_d;

   // Decode signedness, operand magnitudes and special cases of the op on the bus
   always_comb begin
      a_signed   = (bus.funct == 3'b001) || (bus.funct == 3'b010) ||
                   (bus.funct == 3'b100) || (bus.funct == 3'b110);
      b_signed   = (bus.funct == 3'b001) || (bus.funct == 3'b100) || (bus.funct == 3'b110);
      a_neg      = a_signed & bus.rs1[XLEN-1];
      b_neg      = b_signed & bus.rs2[XLEN-1];
      a_abs      = a_neg ? -bus.rs1 : bus.rs1;
      b_abs      = b_neg ? -bus.rs2 : bus.rs2;
      // remainder follows the dividend; product and quotient follow the sign product
      neg_d      = (bus.funct == 3'b110) ? a_neg : (a_neg ^ b_neg);
      div_zero   = bus.funct[2] && (bus.rs2 == '0);
      div_ovf    = ((bus.funct == 3'b100) || (bus.funct == 3'b110)) &&
                   (bus.rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.rs2);
      // DIV overflow returns the dividend, which is the most negative value
      if (bus.funct[1])
         spec_res_d = div_zero ? bus.rs1 : '0;
      else
         spec_res_d = div_zero ? '1 : bus.rs1;
      acc_init_d = {{XLEN{1'b0}}, (bus.funct[2] ? a_abs : b_abs)};
   end

   // One shift-add or restoring shift-subtract step on the accumulator
   always_comb begin
      msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : {(XLEN+1){1'b0}});
      rem_sh = acc_q[2*XLEN-1:XLEN-1];
      // shifted remainder is below twice the divisor, so XLEN+1 signed bits cover the difference
      dsub   = rem_sh - {1'b0, opb_q};
      if (funct_q[2])
         acc_step_d = dsub[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {dsub[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
         acc_step_d = {msum, acc_q[XLEN-1:1]};
   end

   // Sign fix-up and word selection
   always_comb begin
      prod    = neg_q ? -acc_q : acc_q;
      quo_abs = acc_q[XLEN-1:0];
      rem_abs = acc_q[2*XLEN-1:XLEN];
      case (funct_q)
         3'b000:         fix_res_d = prod[XLEN-1:0];
         3'b100, 3'b101: fix_res_d = neg_q ? -quo_abs : quo_abs;
         3'b110, 3'b111: fix_res_d = neg_q ? -rem_abs : rem_abs;
         default:        fix_res_d = prod[2*XLEN-1:XLEN];
      endcase
   end

   // Sequencer FSM with registered result and valid
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= S_IDLE;
         funct_q     <= '0;
         opa_q       <= '0;
         opb_q       <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         neg_q       <= 1'b0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
      end else if (bus.kill) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid) begin
                  funct_q <= bus.funct;
                  opa_q   <= a_abs;
                  opb_q   <= b_abs;
                  acc_q   <= acc_init_d;
                  neg_q   <= neg_d;
                  cnt_q   <= '0;
                  if (div_zero || div_ovf) begin
                     result_q    <= spec_res_d;
                     out_valid_q <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     state_q     <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               acc_q <= acc_step_d;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CW'(XLEN-1))
                  state_q <= S_FIX;
            end
            S_FIX: begin
               result_q    <= fix_res_d;
               out_valid_q <= 1'b1;
               state_q     <= S_DONE;
            end
            default: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_IDLE;
               end
            end
         endcase
      end
   end

   assign bus.in_ready  = (state_q == S_IDLE);
   assign bus.busy      = (state_q != S_IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed cases plus randomized ops against an arithmetic reference.
// Timing checked in edges after the accept edge.
// Exercises result backpressure, back-to-back issue, kill and asynchronous reset.
module tb_muldiv_seq;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   muldiv_seq_if #(.XLEN(32)) bus ();

   muldiv_seq #(.XLEN(32)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // RV32M semantics from plain 64-bit arithmetic
   function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      longint          sa, sb;
      longint unsigned ua, ub;
      logic [63:0]     p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'b0, a};
      ub = {32'b0, b};
      p  = '0;
      case (f)
         3'd0: begin p = ua * ub; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
         3'd5: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
         3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
         default: begin if (b == 0) return a; return a % b; end
      endcase
   endfunction

   function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      return f[2] && ((b == 0) ||
             (((f == 3'd4) || (f == 3'd6)) && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
   endfunction

   // issue one op, wait for the result, hold it for 'stall' cycles, then take it
   task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int stall, input string nm);
      logic [31:0] exp, held;
      int          lat;
      bit          busy_ok;
      exp = ref_res(f, a, b);
      @(negedge clk);
      chk({nm, ":rdy"}, bus.in_ready, 1);
      bus.in_valid = 1'b1;
      bus.funct    = f;
      bus.rs1      = a;
      bus.rs2      = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.funct    = 3'($urandom);
      bus.rs1      = $urandom;
      bus.rs2      = $urandom;
      lat = 0;
      busy_ok = 1'b1;
      while (!bus.out_valid && lat < 100) begin
         if (!bus.busy) busy_ok = 1'b0;
         @(negedge clk);
         lat++;
         bus.rs1 = $urandom;
      end
      chk({nm, ":lat"}, lat, is_special(f, a, b) ? 0 : 33);
      chk({nm, ":res"}, bus.result, exp);
      chk({nm, ":busy"}, busy_ok & bus.busy, 1);
      held = bus.result;
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         chk({nm, ":hold_vld"}, bus.out_valid, 1);
         chk({nm, ":hold_res"}, bus.result, held);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({nm, ":vld_fall"}, bus.out_valid, 0);
      chk({nm, ":idle_rdy"}, bus.in_ready, 1);
      chk({nm, ":res_kept"}, bus.result, held);
   endtask

   initial begin
      logic [2:0]  f;
      logic [31:0] a, b;
      int          sel;
      bit          ok;

      bus.in_valid  = 1'b0;
      bus.funct     = '0;
      bus.rs1       = '0;
      bus.rs2       = '0;
      bus.kill      = 1'b0;
      bus.out_ready = 1'b0;

      // reset state
      #23;
      chk("rst:vld",  bus.out_valid, 0);
      chk("rst:res",  bus.result, 0);
      chk("rst:busy", bus.busy, 0);
      chk("rst:rdy",  bus.in_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;

      // directed arithmetic
      do_op(3'd0, 32'd7,         32'hFFFF_FFFD, 5, "mul");
      do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 0, "mulh");
      do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, "mulhu");
      do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mulhsu");
      do_op(3'd4, 32'hFFFF_FFF9, 32'd2,         0, "div");
      do_op(3'd6, 32'hFFFF_FFF9, 32'd2,         2, "rem");
      do_op(3'd5, 32'd100,       32'd7,         0, "divu");
      do_op(3'd7, 32'd100,       32'd7,         0, "remu");
      do_op(3'd5, 32'h1234,      32'd0,         0, "divu0");
      do_op(3'd6, 32'h1234,      32'd0,         3, "rem0");
      do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
      do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, "rem_ovf");

      // back-to-back with in_valid and out_ready held high
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.funct     = 3'd5;
      bus.rs1       = 32'h1234;
      bus.rs2       = 32'd0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("b2b:vld1", bus.out_valid, 1);
      @(negedge clk);
      chk("b2b:gap_vld", bus.out_valid, 0);
      chk("b2b:gap_rdy", bus.in_ready, 1);
      @(negedge clk);
      chk("b2b:vld2", bus.out_valid, 1);
      chk("b2b:res2", bus.result, 32'hFFFF_FFFF);
      bus.in_valid = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b0;

      // kill outranks accept
      bus.in_valid = 1'b1;
      bus.kill     = 1'b1;
      bus.funct    = 3'd0;
      @(negedge clk);
      chk("killacc:busy", bus.busy, 0);
      bus.in_valid = 1'b0;
      bus.kill     = 1'b0;

      // kill at cycle 10 of CALC
      bus.in_valid = 1'b1;
      bus.funct    = 3'd5;
      bus.rs1      = 32'd100;
      bus.rs2      = 32'd7;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("kill:busy_before", bus.busy, 1);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      chk("kill:busy", bus.busy, 0);
      chk("kill:rdy",  bus.in_ready, 1);
      ok = 1'b1;
      repeat (40) begin
         if (bus.out_valid) ok = 1'b0;
         @(negedge clk);
      end
      chk("kill:no_vld", ok, 1);
      do_op(3'd5, 32'd100, 32'd7, 0, "postkill");

      // kill in DONE together with out_ready
      bus.in_valid = 1'b1;
      bus.funct    = 3'd7;
      bus.rs1      = 32'd9;
      bus.rs2      = 32'd0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      chk("killdone:vld", bus.out_valid, 1);
      bus.kill      = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.kill      = 1'b0;
      bus.out_ready = 1'b0;
      chk("killdone:vld_fall", bus.out_valid, 0);
      chk("killdone:rdy", bus.in_ready, 1);

      // asynchronous reset mid-CALC
      bus.in_valid = 1'b1;
      bus.funct    = 3'd1;
      bus.rs1      = $urandom;
      bus.rs2      = $urandom;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("arst:vld",  bus.out_valid, 0);
      chk("arst:res",  bus.result, 0);
      chk("arst:busy", bus.busy, 0);
      chk("arst:rdy",  bus.in_ready, 1);
      @(negedge clk);
      reset_n = 1'b1;

      // randomized ops
      for (int n = 0; n < 40; n++) begin
         f   = 3'($urandom_range(0, 7));
         sel = $urandom_range(0, 9);
         a   = $urandom;
         b   = $urandom;
         if (sel == 0) b = 32'd0;
         else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
         else if (sel <= 4) begin
            a = $urandom_range(0, 1000);
            b = $urandom_range(1, 50);
            if ($urandom_range(0, 1) == 1) a = -a;
            if ($urandom_range(0, 1) == 1) b = -b;
         end
         do_op(f, a, b, $urandom_range(0, 3), $sformatf("rnd%0d_f%0d", n, f));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
